// File: rtl/vread_pkg.sv
// Shared types and sizing helpers for the external-read unit family.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vread_pkg;

  // Read-side FSM: one request cycle per burst, then beats until last.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_BEAT,
    RD_DONE
  } rd_state_t;

  // Output address generator phases.
  typedef enum logic [1:0] {
    GEN_IDLE,
    GEN_WAIT,
    GEN_READ
  } gen_state_t;

  // AXI bursts must not cross a 4 KB page.
  localparam int unsigned PAGE_BYTES = 4096;
  localparam int          PAGE_W     = 12;

  // Output words packed into one bus word.
  function automatic int calc_diff(input int axi_data_w, input int data_w);
    return axi_data_w / data_w;
  endfunction

  // Offset bits that select the output word inside a bus word.
  function automatic int calc_decision_w(input int axi_data_w, input int data_w);
    return $clog2(axi_data_w / data_w);
  endfunction

  function automatic int calc_buf_w(input int num_buf);
    return $clog2(num_buf);
  endfunction

  function automatic int calc_off_w(input int addr_w, input int num_buf);
    return addr_w - $clog2(num_buf);
  endfunction

endpackage

// File: rtl/vread_out_gen.sv
// Two-level (period x iterations) read-address generator with start delay and bit-reverse.
// Latency: first read the cycle after run when delay=0, otherwise delay cycles later.
// Backpressure: none; one read per cycle once started. run restarts it at any time.
// Ports: run/start/incr/shift/period/iterations/delay/reverse in; rd, offset, done out.
module vread_out_gen
  import vread_pkg::*;
#(
  parameter int OFF_W    = 12,
  parameter int PERIOD_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [OFF_W-1:0]    start,
  input  logic [OFF_W-1:0]    incr,
  input  logic [OFF_W-1:0]    shift,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] iterations,
  input  logic [31:0]         delay,
  input  logic                reverse,
  output logic                rd,
  output logic [OFF_W-1:0]    offset,
  output logic                done
);

  gen_state_t          state_q, state_d;
  logic [OFF_W-1:0]    incr_q, shift_q, base_q, off_q;
  logic [PERIOD_W-1:0] per_q, iter_q, j_q, i_q;
  logic [31:0]         wait_q;
  logic                rev_q;
  logic                last_j, last_i, zero_cfg;

  assign last_j   = (j_q == per_q - 1'b1);
  assign last_i   = (i_q == iter_q - 1'b1);
  assign zero_cfg = (period == '0) || (iterations == '0);

  always_comb begin
    state_d = state_q;
    if (run) begin
      if (zero_cfg)           state_d = GEN_IDLE;
      else if (delay == '0)   state_d = GEN_READ;
      else                    state_d = GEN_WAIT;
    end else begin
      case (state_q)
        GEN_WAIT: if (wait_q == 32'd1) state_d = GEN_READ;
        GEN_READ: if (last_j && last_i) state_d = GEN_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GEN_IDLE;
      incr_q  <= '0;
      shift_q <= '0;
      base_q  <= '0;
      off_q   <= '0;
      per_q   <= '0;
      iter_q  <= '0;
      j_q     <= '0;
      i_q     <= '0;
      wait_q  <= '0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (run) begin
        incr_q  <= incr;
        shift_q <= shift;
        per_q   <= period;
        iter_q  <= iterations;
        wait_q  <= delay;
        rev_q   <= reverse;
        base_q  <= start;
        off_q   <= start;
        j_q     <= '0;
        i_q     <= '0;
      end else begin
        case (state_q)
          GEN_WAIT: wait_q <= wait_q - 32'd1;
          GEN_READ: begin
            if (last_j) begin
              // Outer step: next row starts at the shifted base.
              j_q    <= '0;
              i_q    <= i_q + 1'b1;
              base_q <= base_q + shift_q;
              off_q  <= base_q + shift_q;
            end else begin
              j_q   <= j_q + 1'b1;
              off_q <= off_q + incr_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Bit reversal is applied to the finished offset, not to the operands.
  always_comb begin
    offset = off_q;
    if (rev_q) begin
      for (int b = 0; b < OFF_W; b++) offset[b] = off_q[OFF_W-1-b];
    end
  end

  assign rd   = (state_q == GEN_READ);
  assign done = (state_q == GEN_IDLE);

endmodule

// File: rtl/vread_multibuf.sv
// External-read unit: bursts `amount` bus words into a rotating N-buffer, replays the previous buffer on out0.
// Latency: databus_valid_0 the cycle after run; buffer write combinational with each accepted beat; out0 one cycle after each read.
// Backpressure: beats accepted only on valid&ready; REQ bubble between bursts; run aborts and restarts both engines.
// Ports: databus_* AXI-like read master; ext_2p_* two-port buffer; out0 output word; run/done control; config sampled on run.
module vread_multibuf
  import vread_pkg::*;
#(
  parameter int   DATA_W     = 32,
  parameter int   AXI_DATA_W = 32,
  parameter int   AXI_ADDR_W = 32,
  parameter int   ADDR_W     = 12,
  parameter int   NUM_BUF    = 2,
  parameter int   LEN_W      = 8,
  parameter int   AMOUNT_W   = 16,
  parameter int   PERIOD_W   = 10,
  localparam int  BUF_W      = calc_buf_w(NUM_BUF),
  localparam int  OFF_W      = calc_off_w(ADDR_W, NUM_BUF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  done,
  output logic                  databus_valid_0,
  input  logic                  databus_ready_0,
  output logic [AXI_ADDR_W-1:0] databus_addr_0,
  output logic [LEN_W-1:0]      databus_len_0,
  input  logic [AXI_DATA_W-1:0] databus_rdata_0,
  input  logic                  databus_last_0,
  output logic                  ext_2p_write_0,
  output logic [ADDR_W-1:0]     ext_2p_addr_out_0,
  output logic [AXI_DATA_W-1:0] ext_2p_data_out_0,
  output logic                  ext_2p_read_0,
  output logic [ADDR_W-1:0]     ext_2p_addr_in_0,
  input  logic [AXI_DATA_W-1:0] ext_2p_data_in_0,
  output logic [DATA_W-1:0]     out0,
  input  logic [AXI_ADDR_W-1:0] ext_addr,
  input  logic [AMOUNT_W-1:0]   amount,
  input  logic                  enableRead,
  input  logic                  pingPong,
  input  logic [OFF_W-1:0]      start,
  input  logic [OFF_W-1:0]      incr,
  input  logic [OFF_W-1:0]      shift,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [PERIOD_W-1:0]   iterations,
  input  logic [31:0]           delay,
  input  logic                  reverse
);

  localparam int          DEC_W     = calc_decision_w(AXI_DATA_W, DATA_W);
  localparam int unsigned AXI_BYTES = AXI_DATA_W / 8;
  localparam int          BYTE_SH   = $clog2(AXI_DATA_W / 8);
  localparam int unsigned MAX_LEN   = 1 << LEN_W;
  localparam int          BUF_R     = (BUF_W > 0) ? BUF_W : 1;

  rd_state_t             state_q, state_d;
  logic [AMOUNT_W-1:0]   rem_q;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [OFF_W-1:0]      wr_off_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W:0]        beats_q;
  logic [BUF_R-1:0]      wr_buf_q, rd_buf_q;
  logic                  first_q;
  logic [31:0]           page_left, beats_c;
  logic                  beat_acc;
  logic                  gen_rd, gen_done;
  logic [OFF_W-1:0]      gen_off, rd_off_mem;

  // Burst size: limited by what is left, by the length field and by the page end.
  always_comb begin
    page_left = (32'(PAGE_BYTES) - 32'(addr_q[PAGE_W-1:0])) >> BYTE_SH;
    beats_c   = 32'(rem_q);
    if (beats_c > 32'(MAX_LEN)) beats_c = 32'(MAX_LEN);
    if (beats_c > page_left)    beats_c = page_left;
  end

  // A run in the same cycle drops the beat: it belongs to the aborted transfer.
  assign beat_acc = (state_q == RD_BEAT) && databus_ready_0 && !run;

  always_comb begin
    state_d = state_q;
    if (run) begin
      state_d = (enableRead && (amount != '0)) ? RD_REQ : RD_DONE;
    end else begin
      case (state_q)
        RD_REQ:  state_d = RD_BEAT;
        RD_BEAT: if (beat_acc && databus_last_0)
                   state_d = (rem_q == AMOUNT_W'(1)) ? RD_DONE : RD_REQ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RD_IDLE;
      rem_q    <= '0;
      addr_q   <= '0;
      wr_off_q <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      wr_buf_q <= '0;
      rd_buf_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= run;
      if (run) begin
        rem_q    <= amount;
        addr_q   <= ext_addr;
        wr_off_q <= '0;
        // The buffer just filled becomes the one replayed.
        wr_buf_q <= (pingPong && BUF_W > 0) ? wr_buf_q + 1'b1 : '0;
        rd_buf_q <= (pingPong && BUF_W > 0) ? wr_buf_q : '0;
      end else begin
        if (state_q == RD_REQ) begin
          len_q   <= LEN_W'(beats_c - 32'd1);
          beats_q <= (LEN_W+1)'(beats_c);
        end
        if (beat_acc) begin
          wr_off_q <= wr_off_q + 1'b1;
          rem_q    <= rem_q - 1'b1;
          if (databus_last_0)
            addr_q <= addr_q + AXI_ADDR_W'(32'(beats_q) * AXI_BYTES);
        end
      end
    end
  end

  assign databus_valid_0   = (state_q == RD_REQ) || (state_q == RD_BEAT);
  assign databus_addr_0    = addr_q;
  // Length is live during REQ and frozen for the rest of the burst.
  assign databus_len_0     = (state_q == RD_REQ) ? LEN_W'(beats_c - 32'd1) : len_q;
  assign ext_2p_write_0    = beat_acc;
  assign ext_2p_data_out_0 = beat_acc ? databus_rdata_0 : '0;
  assign ext_2p_read_0     = gen_rd;
  // first_q forces done low for the cycle after run even if nothing is to be done.
  assign done = ((state_q == RD_IDLE) || (state_q == RD_DONE)) && gen_done && !first_q;

  vread_out_gen #(
    .OFF_W    (OFF_W),
    .PERIOD_W (PERIOD_W)
  ) u_out_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .start      (start),
    .incr       (incr),
    .shift      (shift),
    .period     (period),
    .iterations (iterations),
    .delay      (delay),
    .reverse    (reverse),
    .rd         (gen_rd),
    .offset     (gen_off),
    .done       (gen_done)
  );

  // Width adapter: high offset bits address the bus word, low bits pick the lane.
  if (DEC_W > 0) begin : g_adapt
    logic [DEC_W-1:0] sel_q;
    assign rd_off_mem = gen_off >> DEC_W;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         sel_q <= '0;
      else if (gen_rd) sel_q <= gen_off[DEC_W-1:0];
    end
    assign out0 = ext_2p_data_in_0[sel_q*DATA_W +: DATA_W];
  end else begin : g_direct
    assign rd_off_mem = gen_off;
    assign out0       = ext_2p_data_in_0;
  end

  if (BUF_W > 0) begin : g_bufsel
    assign ext_2p_addr_out_0 = {wr_buf_q, wr_off_q};
    assign ext_2p_addr_in_0  = {rd_buf_q, rd_off_mem};
  end else begin : g_single
    assign ext_2p_addr_out_0 = wr_off_q;
    assign ext_2p_addr_in_0  = rd_off_mem;
  end

endmodule

// File: tb/tb_vread_multibuf.sv
// Directed bench for vread_multibuf (4 buffers, 64b bus, 32b output).
// Latency: n/a.
// Backpressure: bench slave inserts optional random ready gaps.
module tb_vread_multibuf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        done;
  logic        databus_valid_0;
  logic        databus_ready_0 = 1'b0;
  logic [31:0] databus_addr_0;
  logic [7:0]  databus_len_0;
  logic [63:0] databus_rdata_0 = '0;
  logic        databus_last_0 = 1'b0;
  logic        ext_2p_write_0;
  logic [11:0] ext_2p_addr_out_0;
  logic [63:0] ext_2p_data_out_0;
  logic        ext_2p_read_0;
  logic [11:0] ext_2p_addr_in_0;
  logic [63:0] ext_2p_data_in_0 = '0;
  logic [31:0] out0;
  logic [31:0] ext_addr = '0;
  logic [15:0] amount = '0;
  logic        enableRead = 1'b0;
  logic        pingPong = 1'b0;
  logic [9:0]  start = '0, incr = '0, shift = '0;
  logic [9:0]  period = '0, iterations = '0;
  logic [31:0] delay = '0;
  logic        reverse = 1'b0;

  vread_multibuf #(
    .DATA_W(32), .AXI_DATA_W(64), .AXI_ADDR_W(32), .ADDR_W(12),
    .NUM_BUF(4), .LEN_W(8), .AMOUNT_W(16), .PERIOD_W(10)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .done(done),
    .databus_valid_0(databus_valid_0), .databus_ready_0(databus_ready_0),
    .databus_addr_0(databus_addr_0), .databus_len_0(databus_len_0),
    .databus_rdata_0(databus_rdata_0), .databus_last_0(databus_last_0),
    .ext_2p_write_0(ext_2p_write_0), .ext_2p_addr_out_0(ext_2p_addr_out_0),
    .ext_2p_data_out_0(ext_2p_data_out_0), .ext_2p_read_0(ext_2p_read_0),
    .ext_2p_addr_in_0(ext_2p_addr_in_0), .ext_2p_data_in_0(ext_2p_data_in_0),
    .out0(out0), .ext_addr(ext_addr), .amount(amount), .enableRead(enableRead),
    .pingPong(pingPong), .start(start), .incr(incr), .shift(shift),
    .period(period), .iterations(iterations), .delay(delay), .reverse(reverse)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // External memory content: each bus word is derived from its byte address.
  function automatic logic [63:0] word(input logic [31:0] a);
    return {a + 32'h1000_0000, a};
  endfunction

  // Buffer RAM model and monitors.
  logic [63:0] bufmem [0:4095];
  int cyc = 0, last_cyc = 0, write_cnt = 0, viol = 0, len_bad = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ext_2p_write_0) begin
      bufmem[ext_2p_addr_out_0] <= ext_2p_data_out_0;
      write_cnt <= write_cnt + 1;
      if (!(databus_valid_0 && databus_ready_0)) viol <= viol + 1;
    end
    if (ext_2p_read_0) ext_2p_data_in_0 <= bufmem[ext_2p_addr_in_0];
    if (databus_valid_0 && databus_ready_0 && databus_last_0) last_cyc <= cyc;
  end

  // Memory slave: latches one request, then returns len+1 beats.
  int          gap_mode = 0;
  logic        sl_busy = 1'b0;
  logic [31:0] sl_addr = '0;
  logic [7:0]  sl_len = '0;
  int          sl_idx = 0;
  logic [31:0] burst_addr [0:31];
  logic [7:0]  burst_len  [0:31];
  int          burst_n = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sl_busy <= 1'b0;
      sl_idx  <= 0;
    end else if (run) begin
      sl_busy <= 1'b0;
    end else if (sl_busy) begin
      if (databus_valid_0 && databus_len_0 != sl_len) len_bad <= len_bad + 1;
      if (databus_valid_0 && databus_ready_0) begin
        sl_idx <= sl_idx + 1;
        if (databus_last_0) sl_busy <= 1'b0;
      end
    end else if (databus_valid_0) begin
      sl_busy <= 1'b1;
      sl_addr <= databus_addr_0;
      sl_len  <= databus_len_0;
      sl_idx  <= 0;
      burst_addr[burst_n[4:0]] <= databus_addr_0;
      burst_len[burst_n[4:0]]  <= databus_len_0;
      burst_n <= burst_n + 1;
    end
  end

  always @(negedge clk) begin
    databus_ready_0 = sl_busy && (gap_mode == 0 || $urandom_range(0, 2) != 0);
    databus_rdata_0 = word(sl_addr + 32'(sl_idx) * 32'd8);
    databus_last_0  = sl_busy && (sl_idx == int'(sl_len));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_run;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  int done_cyc = 0;
  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", done, 1);
    done_cyc = cyc;
  endtask

  int wc0, b0, v0, lb0;

  initial begin
    // ---------------- reset state
    #12;
    check("rst_done", done, 1);
    check("rst_valid", databus_valid_0, 0);
    check("rst_write", ext_2p_write_0, 0);
    check("rst_read", ext_2p_read_0, 0);
    check("rst_bus_addr", databus_addr_0, 0);
    check("rst_len", databus_len_0, 0);
    check("rst_addr_out", ext_2p_addr_out_0, 0);
    check("rst_addr_in", ext_2p_addr_in_0, 0);
    check("rst_data_out", ext_2p_data_out_0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- A: page-boundary split, buffer 1
    ext_addr = 32'h0FC0; amount = 16'd300; enableRead = 1'b1; pingPong = 1'b1;
    period = '0; iterations = '0; delay = '0;
    wc0 = write_cnt; b0 = burst_n;
    pulse_run();
    check("A_valid", databus_valid_0, 1);
    check("A_done_low", done, 0);
    check("A_len0", databus_len_0, 7);
    check("A_addr0", databus_addr_0, 32'h0FC0);
    wait_done(2000);
    check("A_done_after_last", done_cyc - last_cyc, 1);
    check("A_bursts", burst_n - b0, 3);
    check("A_b0_addr", burst_addr[b0], 32'h0FC0);
    check("A_b1_addr", burst_addr[b0+1], 32'h1000);
    check("A_b1_len", burst_len[b0+1], 255);
    check("A_b2_addr", burst_addr[b0+2], 32'h1800);
    check("A_b2_len", burst_len[b0+2], 35);
    check("A_writes", write_cnt - wc0, 300);
    check("A_mem0", bufmem[1024], word(32'h0FC0));
    check("A_mem8", bufmem[1024+8], word(32'h1000));
    check("A_mem299", bufmem[1024+299], word(32'h1918));

    // ---------------- B: random ready gaps, buffer 2
    gap_mode = 1;
    ext_addr = 32'h2000; amount = 16'd40;
    wc0 = write_cnt; b0 = burst_n; v0 = viol; lb0 = len_bad;
    pulse_run();
    check("B_len", databus_len_0, 39);
    wait_done(2000);
    check("B_done_after_last", done_cyc - last_cyc, 1);
    check("B_writes", write_cnt - wc0, 40);
    check("B_write_wo_hs", viol - v0, 0);
    check("B_len_stable", len_bad - lb0, 0);
    check("B_mem39", bufmem[2048+39], word(32'h2138));
    gap_mode = 0;

    // ---------------- C: width adapter replaying buffer 2, no read
    enableRead = 1'b0; amount = 16'd0;
    start = 10'd0; incr = 10'd1; shift = 10'd0; period = 10'd4; iterations = 10'd1;
    pulse_run();
    check("C_valid", databus_valid_0, 0);
    check("C_done_low", done, 0);
    check("C_rd1", ext_2p_read_0, 1);
    check("C_a1", ext_2p_addr_in_0, 2048);
    @(negedge clk);
    check("C_a2", ext_2p_addr_in_0, 2048);
    check("C_o1", out0, 32'h0000_2000);
    @(negedge clk);
    check("C_a3", ext_2p_addr_in_0, 2049);
    check("C_o2", out0, 32'h1000_2000);
    @(negedge clk);
    check("C_a4", ext_2p_addr_in_0, 2049);
    check("C_o3", out0, 32'h0000_2008);
    @(negedge clk);
    check("C_rd_end", ext_2p_read_0, 0);
    check("C_o4", out0, 32'h1000_2008);
    check("C_done", done, 1);

    // ---------------- D: delay + reverse + outer step, write into buffer 0
    enableRead = 1'b1; ext_addr = 32'h3000; amount = 16'd4;
    start = 10'd1; incr = 10'd2; shift = 10'd4; period = 10'd2; iterations = 10'd2;
    delay = 32'd3; reverse = 1'b1;
    pulse_run();
    check("D_len", databus_len_0, 3);
    check("D_rd_wait1", ext_2p_read_0, 0);
    @(negedge clk);
    @(negedge clk);
    check("D_rd_wait3", ext_2p_read_0, 0);
    @(negedge clk);
    check("D_rd1", ext_2p_read_0, 1);
    check("D_a1", ext_2p_addr_in_0, 3328);
    @(negedge clk);
    check("D_a2", ext_2p_addr_in_0, 3456);
    @(negedge clk);
    check("D_a3", ext_2p_addr_in_0, 3392);
    @(negedge clk);
    check("D_a4", ext_2p_addr_in_0, 3520);
    check("D_done_low", done, 0);
    @(negedge clk);
    check("D_rd_end", ext_2p_read_0, 0);
    check("D_done", done, 1);
    check("D_mem0", bufmem[0], word(32'h3000));
    check("D_mem3", bufmem[3], word(32'h3018));

    // ---------------- E: ring wrap, replay buffer 0 with amount=0
    amount = 16'd0; start = 10'd0; incr = 10'd1; period = 10'd2; iterations = 10'd1;
    delay = 32'd0; reverse = 1'b0;
    pulse_run();
    check("E_valid", databus_valid_0, 0);
    check("E_a1", ext_2p_addr_in_0, 0);
    @(negedge clk);
    check("E_o1", out0, 32'h0000_3000);
    @(negedge clk);
    check("E_o2", out0, 32'h1000_3000);
    check("E_done", done, 1);

    // ---------------- G: fully degenerate, pingPong=0 pins buffer 0
    pingPong = 1'b0; enableRead = 1'b0; period = 10'd0;
    pulse_run();
    check("G_done_low", done, 0);
    check("G_valid", databus_valid_0, 0);
    check("G_read", ext_2p_read_0, 0);
    @(negedge clk);
    check("G_done", done, 1);

    // ---------------- H: abort after 10 of 64 beats
    pingPong = 1'b1; enableRead = 1'b1; ext_addr = 32'h4000; amount = 16'd64;
    wc0 = write_cnt;
    pulse_run();
    check("H_len", databus_len_0, 63);
    for (int k = 0; k < 200 && (write_cnt - wc0) < 10; k++) @(negedge clk);
    check("H_ten_beats", write_cnt - wc0, 10);
    ext_addr = 32'h5000; amount = 16'd8;
    pulse_run();
    check("H_restart_valid", databus_valid_0, 1);
    check("H_restart_addr", databus_addr_0, 32'h5000);
    check("H_restart_len", databus_len_0, 7);
    wait_done(500);
    check("H_writes", write_cnt - wc0, 18);
    check("H_old9", bufmem[1024+9], word(32'h4048));
    check("H_old10_kept", bufmem[1024+10], word(32'h1010));
    check("H_new0", bufmem[2048], word(32'h5000));
    check("H_new7", bufmem[2048+7], word(32'h5038));

    // ---------------- F: async reset mid-BEAT, then buffers restart at 1
    ext_addr = 32'h6000; amount = 16'd32;
    pulse_run();
    repeat (5) @(negedge clk);
    check("F_pre_write", ext_2p_write_0, 1);
    #2 rst = 1'b1;
    #1;
    check("F_valid", databus_valid_0, 0);
    check("F_write", ext_2p_write_0, 0);
    check("F_read", ext_2p_read_0, 0);
    check("F_bus_addr", databus_addr_0, 0);
    check("F_len", databus_len_0, 0);
    check("F_addr_out", ext_2p_addr_out_0, 0);
    check("F_data_out", ext_2p_data_out_0, 0);
    check("F_done", done, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ext_addr = 32'h7000; amount = 16'd1;
    pulse_run();
    wait_done(100);
    check("F_buf_after_rst", bufmem[1024], word(32'h7000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
